alu_op_sequencer: RTL and testbench

//  Command-side front end for the 16-bit ALU. Buffers {A,B,sel} operations in a small FIFO and drives one op at a time onto the ALU's combinational inputs.

---
 rtl/alu_op_sequencer.sv | 83 ++++++++
 tb/tb_alu_op_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers {A,B,sel} commands, drives them one at a time into the ALU and
// returns each captured result on a valid/ready port with zero and illegal-opcode flags.
module alu_op_sequencer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_a,
  input  logic [DATA_W-1:0]             in_b,
  input  logic [2:0]                    in_sel,
  output logic [DATA_W-1:0]             alu_a,
  output logic [DATA_W-1:0]             alu_b,
  output logic [2:0]                    alu_sel,
  input  logic [DATA_W-1:0]             alu_c,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_result,
  output logic [2:0]                    out_sel,
  output logic                          out_zero,
  output logic                          out_illegal,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = 2 * DATA_W + 3;
  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
  state_t        r_state;
  logic [OW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          r_rdy_en;
  logic          w_push;
  logic          w_pop;
  // r_rdy_en keeps in_ready low through reset and the first edge after release
  assign in_ready   = r_rdy_en && (r_count < CW'(FIFO_DEPTH));
  assign w_push     = in_valid && in_ready;
  assign w_pop      = (r_count != '0) && (r_state == IDLE || (r_state == HOLD && out_ready));
  assign fifo_count = r_count;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= {in_a, in_b, in_sel};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rdy_en    <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_sel     <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_sel     <= '0;
      out_zero    <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push != w_pop) r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
      if (w_pop) {alu_a, alu_b, alu_sel} <= r_mem[r_rptr];
      case (r_state)
        IDLE: if (w_pop) r_state <= DRIVE;
        DRIVE: begin
          out_result  <= alu_c;
          out_sel     <= alu_sel;
          out_zero    <= (alu_c == '0);
          out_illegal <= alu_sel[2] && (alu_sel != 3'b111);
          out_valid   <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          r_state   <= w_pop ? DRIVE : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random checks of alu_op_sequencer against a behavioural ALU.
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [2:0]  in_sel;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_sel;
  logic [15:0] alu_c;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_sel;
  logic        out_zero;
  logic        out_illegal;
  logic [2:0]  fifo_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b111:  return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_c = alu(alu_a, alu_b, alu_sel);

  alu_op_sequencer #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_sel(out_sel), .out_zero(out_zero), .out_illegal(out_illegal),
    .fifo_count(fifo_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
    in_a = a;
    in_b = b;
    in_sel = s;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // waits (bounded) for a result, checks it, then lets the handshake complete
  task automatic expect_res(input string tag, input logic [15:0] r, input logic [2:0] s);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_res"}, out_result, r);
    check({tag, "_sel"}, out_sel, s);
    check({tag, "_zero"}, out_zero, r == 16'h0);
    check({tag, "_ill"}, out_illegal, s == 3'd4 || s == 3'd5 || s == 3'd6);
    step();
  endtask

  initial begin
    int acc;
    logic any;
    logic [18:0] e;
    logic [18:0] q[$];
    int sent;
    int got;
    int maxc;
    int n;
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_sel = '0;
    out_ready = 1'b0;
    #3 rst_n = 1'b0;
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_out_result", out_result, 0);
    rst_n = 1'b1;
    check("rel_in_ready_low", in_ready, 0);
    step();
    check("rel_in_ready_high", in_ready, 1);

    // single add: pop one edge after accept, capture the next, one-cycle pulse
    out_ready = 1'b1;
    send(16'h1234, 16'h0101, 3'b000);
    check("t1_count", fifo_count, 1);
    check("t1_valid_n1", out_valid, 0);
    step();
    check("t1_alu_a", alu_a, 16'h1234);
    check("t1_alu_b", alu_b, 16'h0101);
    check("t1_count_pop", fifo_count, 0);
    check("t1_valid_n2", out_valid, 0);
    step();
    check("t1_valid", out_valid, 1);
    check("t1_res", out_result, 16'h1335);
    check("t1_zero", out_zero, 0);
    check("t1_sel", out_sel, 0);
    step();
    check("t1_pulse_end", out_valid, 0);

    send(16'h0000, 16'h0001, 3'b001);
    expect_res("t2_sub_wrap", 16'hFFFF, 3'b001);
    send(16'hFFFF, 16'h0001, 3'b000);
    expect_res("t2_add_wrap", 16'h0000, 3'b000);
    send(16'hF0F0, 16'h0FF0, 3'b010);
    expect_res("t2_and", 16'h00F0, 3'b010);
    send(16'hF0F0, 16'h0FF0, 3'b011);
    expect_res("t2_or", 16'hFFF0, 3'b011);
    send(16'hF0F0, 16'h0FF0, 3'b111);
    expect_res("t2_xor", 16'hFF00, 3'b111);

    // backpressure: six back-to-back pushes, five fit
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_a = 16'h1000 + 16'(i);
      in_b = 16'(i);
      in_sel = 3'b000;
      in_valid = 1'b1;
      if (in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check("t3_accepted", acc, 5);
    check("t3_in_ready", in_ready, 0);
    check("t3_count", fifo_count, 4);
    check("t3_valid_held", out_valid, 1);
    check("t3_held_res", out_result, 16'h1000);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_res($sformatf("t3_drain%0d", i), 16'h1000 + 16'(2 * i), 3'b000);
    check("t3_empty", fifo_count, 0);
    check("t3_no_extra", out_valid, 0);

    send(16'hAAAA, 16'h5555, 3'b101);
    expect_res("t4_illegal", 16'h0000, 3'b101);

    // reset while holding a result with three commands queued
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = 16'(i + 1);
      in_b = 16'h0001;
      in_sel = 3'b000;
      step();
    end
    in_valid = 1'b0;
    check("t5_hold", out_valid, 1);
    check("t5_count3", fifo_count, 3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_count", fifo_count, 0);
    check("t5_rst_res", out_result, 0);
    check("t5_rst_alu_a", alu_a, 0);
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      any |= out_valid;
    end
    check("t5_no_output", any, 0);
    check("t5_count_after", fifo_count, 0);

    // random traffic against a scoreboard queue
    sent = 0;
    got = 0;
    maxc = 0;
    n = 0;
    while ((sent < 1000 || q.size() != 0) && n < 20000) begin
      in_valid = (sent < 1000) && ($urandom_range(0, 9) < 6);
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      in_sel = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      if (in_valid && in_ready) begin
        q.push_back({alu(in_a, in_b, in_sel), in_sel});
        sent++;
      end
      if (out_valid && out_ready) begin
        check("rnd_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("rnd_res_sel", {out_result, out_sel}, e);
          check("rnd_zero", out_zero, e[18:3] == 16'h0);
          got++;
        end
      end
      step();
      n++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    end
    in_valid = 1'b0;
    check("rnd_all_results", got, 1000);
    check("rnd_max_count", maxc <= 4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
